read_ptr_status: RTL and testbench
==================================

READ_PTR_STATUS -- requirements
Module: read_ptr_status

Interface
REQ-001 Parameter ADDRSIZE, default 4: memory address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
REQ-002 Parameter AE_RESET, default 1: reset value loaded into the almost-empty threshold register.
REQ-003 rclk  in  1  read-domain clock; every register in the block is clocked by rclk only.
REQ-004 rrst  in  1  reset, asynchronous assert, active-high; no synchronous reset exists.
REQ-005 rq2_wptr  in  ADDRSIZE+1  write pointer in Gray code, already double-synchronised into rclk.
REQ-006 rinc  in  1  read request.
REQ-007 rflush  in  1  discard all stored words.
REQ-008 ae_wr  in  1  load ae_thresh into the threshold register.
REQ-009 ae_thresh  in  ADDRSIZE+1  almost-empty threshold value.
REQ-010 uf_clr  in  1  clear sticky underflow flag.
REQ-011 raddr  out  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0].
REQ-012 rptr  out  ADDRSIZE+1  registered Gray read pointer, sent to the write domain.
REQ-013 rden  out  1  combinational memory read enable = rinc & ~rempty & ~rflush.
REQ-014 rempty  out  1  registered empty flag.
REQ-015 ralmost_empty  out  1  registered almost-empty flag.
REQ-016 rlevel  out  ADDRSIZE+1  registered occupancy, in words.
REQ-017 runderflow  out  1  sticky underflow flag.

Function
REQ-018 wbin = Gray-to-binary of rq2_wptr, combinational, ADDRSIZE+1 bits.
REQ-019 rbinnext: rflush=1 -> wbin; else rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1).
REQ-020 rflush takes priority over rinc in the same cycle; rden=0 that cycle.
REQ-021 rgraynext = (rbinnext >> 1) ^ rbinnext; on each rclk edge rbin<=rbinnext and rptr<=rgraynext.
REQ-022 On each edge rempty <= (rgraynext == rq2_wptr); a flush therefore gives rempty=1 on the next cycle.
REQ-023 levnext = (wbin - rbinnext) modulo 2^(ADDRSIZE+1); on each edge rlevel <= levnext.
REQ-024 rlevel range is 0..2^ADDRSIZE; full occupancy is 2^ADDRSIZE, the MSB-only value.
REQ-025 On each edge ralmost_empty <= (levnext <= thr), with thr = threshold register value before any same-cycle ae_wr.
REQ-026 ae_wr=1 -> threshold register <= ae_thresh; the new value affects ralmost_empty from the following edge.
REQ-027 thr=0 -> ralmost_empty equals rempty; thr >= 2^ADDRSIZE -> ralmost_empty is 1 constantly.
REQ-028 rinc=1 with rempty=1 and rflush=0: pointer holds and runderflow <= 1.
REQ-029 runderflow stays set until uf_clr=1; if an underflow and uf_clr occur in the same cycle, set wins.
REQ-030 Pointer wrap: rbin rolls from 2^(ADDRSIZE+1)-1 to 0 with no glitch in rempty or rlevel; the rptr Gray sequence changes by one bit per increment.
REQ-031 A flush may change rptr by more than one bit. The write side tolerates this because the new value equals an already-synchronised write pointer.
REQ-032 rq2_wptr may change on any cycle; the flags reflect the value present at the edge, so each flag lags rq2_wptr by one cycle.

Reset
REQ-033 While rrst=1, outputs hold: rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0.
REQ-034 While rrst=1, the threshold register holds AE_RESET.
REQ-035 Reset asserted mid-operation forces REQ-033/034 values immediately, without a clock edge.
REQ-036 Release is synchronous to the next rclk edge, and outputs follow REQ-018..032 from that edge onward.
REQ-037 rden is combinational and may be 1 during reset only if rempty is 0; because rempty=1 in reset, rden=0 during reset.

Verification (ADDRSIZE=4, AE_RESET=1)
REQ-038 Step rq2_wptr through Gray(0..3) with rinc=0 -> rlevel 1,2,3 one cycle later; rempty=0; ralmost_empty=1 at level 1 and 0 at levels 2 and 3.
REQ-039 With wbin=16 and rinc held for 16 cycles -> raddr 0..15; rlevel 16 down to 0; rempty=1 on the cycle after the 16th read; rden=0 afterwards.
REQ-040 From empty state, rinc=1 for 1 cycle -> rptr unchanged, runderflow=1; then uf_clr=1 together with another underflow -> runderflow stays 1; uf_clr alone -> runderflow 0.
REQ-041 With rbin=5, wbin=12, pulse rflush together with rinc -> rbin=12, rptr=Gray(12), rempty=1, rlevel=0, rden=0 in that cycle.
REQ-042 Apply ae_wr with ae_thresh=6 at level 6, then read one word -> ralmost_empty changes 0->1 only after the threshold-load edge; level 5 -> ralmost_empty=1.
REQ-043 Run continuous writes and reads across 3 pointer wraps (>96 words), then assert rrst mid-stream -> rlevel always equals the model value; rptr changes by one bit per increment; all REQ-033 values appear asynchronously.

Source files
------------

// File: rtl/read_ptr_status.sv
// Read-side pointer and status logic for an asynchronous FIFO: Gray read pointer,
// empty / almost-empty / occupancy flags, flush and sticky underflow.
module read_ptr_status #(
  parameter int ADDRSIZE = 4,
  parameter int AE_RESET = 1
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                rinc,
  input  logic                rflush,
  input  logic                ae_wr,
  input  logic [ADDRSIZE:0]   ae_thresh,
  input  logic                uf_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rden,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam logic [ADDRSIZE:0] THR_RST = (ADDRSIZE+1)'(AE_RESET);

  logic [ADDRSIZE:0] r_bin;
  logic [ADDRSIZE:0] r_ptr;
  logic [ADDRSIZE:0] r_thr;
  logic [ADDRSIZE:0] r_level;
  logic              r_empty;
  logic              r_almost_empty;
  logic              r_underflow;

  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_rbinnext;
  logic [ADDRSIZE:0] w_rgraynext;
  logic [ADDRSIZE:0] w_levnext;
  logic              w_inc;
  logic              w_uf_set;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    w_wbin = '0;
    for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
      w_wbin[i] = ^(rq2_wptr >> i);
    end
  end

  always_comb begin
    w_inc       = rinc & ~r_empty;
    w_uf_set    = rinc & r_empty & ~rflush;
    w_rbinnext  = rflush ? w_wbin : r_bin + {{ADDRSIZE{1'b0}}, w_inc};
    w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;
    w_levnext   = w_wbin - w_rbinnext;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
      r_underflow    <= 1'b0;
      r_thr          <= THR_RST;
    end else begin
      r_bin          <= w_rbinnext;
      r_ptr          <= w_rgraynext;
      r_empty        <= (w_rgraynext == rq2_wptr);
      r_almost_empty <= (w_levnext <= r_thr);
      r_level        <= w_levnext;
      if (w_uf_set) begin
        r_underflow <= 1'b1;
      end else if (uf_clr) begin
        r_underflow <= 1'b0;
      end
      if (ae_wr) begin
        r_thr <= ae_thresh;
      end
    end
  end

  assign raddr         = r_bin[ADDRSIZE-1:0];
  assign rptr          = r_ptr;
  assign rden          = rinc & ~r_empty & ~rflush;
  assign rempty        = r_empty;
  assign ralmost_empty = r_almost_empty;
  assign rlevel        = r_level;
  assign runderflow    = r_underflow;

endmodule

// File: tb/tb_read_ptr_status.sv
// Bench for read_ptr_status: a write/read count model pushes expected outputs
// into a queue at drive time; a monitor pops and compares after each edge.
module tb_read_ptr_status;

  localparam int AW = 4;
  localparam int AE = 1;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic [AW:0]   rq2_wptr = '0;
  logic          rinc = 1'b0;
  logic          rflush = 1'b0;
  logic          ae_wr = 1'b0;
  logic [AW:0]   ae_thresh = '0;
  logic          uf_clr = 1'b0;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rden;
  logic          rempty;
  logic          ralmost_empty;
  logic [AW:0]   rlevel;
  logic          runderflow;

  read_ptr_status #(.ADDRSIZE(AW), .AE_RESET(AE)) dut (
    .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rinc(rinc), .rflush(rflush),
    .ae_wr(ae_wr), .ae_thresh(ae_thresh), .uf_clr(uf_clr), .raddr(raddr),
    .rptr(rptr), .rden(rden), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [AW:0]   ptr;
    logic [AW-1:0] addr;
    logic          empty;
    logic          ae;
    logic [AW:0]   lev;
    logic          uf;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Model state: m_w = writes seen, m_r = reads taken (both modulo 2^(AW+1)).
  logic [AW:0] m_w, m_r, m_thr;
  logic        m_empty, m_uf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  always @(posedge rclk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rptr", rptr, e.ptr);
      check("raddr", raddr, e.addr);
      check("rempty", rempty, e.empty);
      check("ralmost_empty", ralmost_empty, e.ae);
      check("rlevel", rlevel, e.lev);
      check("runderflow", runderflow, e.uf);
    end
  end

  task automatic model_reset();
    m_w = '0; m_r = '0; m_thr = AE[AW:0]; m_empty = 1'b1; m_uf = 1'b0;
  endtask

  task automatic step(input logic inc, input logic fl, input logic aw,
                      input logic [AW:0] at, input logic uc);
    exp_t        e;
    logic        rd;
    logic [AW:0] rn, lev, prev;
    @(negedge rclk);
    rq2_wptr = gray(m_w); rinc = inc; rflush = fl; ae_wr = aw; ae_thresh = at; uf_clr = uc;
    #1;
    rd = inc & ~m_empty & ~fl;
    check("rden", rden, rd);
    check("raddr_pre", raddr, m_r[AW-1:0]);
    rn  = fl ? m_w : m_r + {{AW{1'b0}}, rd};
    lev = m_w - rn;
    e.ptr   = gray(rn);
    e.addr  = rn[AW-1:0];
    e.empty = (lev == 0);
    e.ae    = (lev <= m_thr);
    e.lev   = lev;
    e.uf    = (inc & m_empty & ~fl) ? 1'b1 : (uc ? 1'b0 : m_uf);
    q.push_back(e);
    prev = rptr;
    m_r = rn; m_empty = e.empty; m_uf = e.uf;
    if (aw) m_thr = at;
    @(posedge rclk);
    #2;
    if (rd) check("gray_one_bit", $countones(rptr ^ prev), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rptr"}, rptr, 0);
    check({tag, "_raddr"}, raddr, 0);
    check({tag, "_rempty"}, rempty, 1);
    check({tag, "_ralmost_empty"}, ralmost_empty, 1);
    check({tag, "_rlevel"}, rlevel, 0);
    check({tag, "_runderflow"}, runderflow, 0);
    check({tag, "_rden"}, rden, 0);
  endtask

  initial begin
    logic [AW:0] d;
    int reads;
    model_reset();
    rinc = 1'b1; rq2_wptr = gray(5'd3);
    #12;
    check_reset("rst");
    @(negedge rclk);
    rrst = 1'b0; rinc = 1'b0; rq2_wptr = '0;

    // Occupancy ramp with no reads
    for (int i = 1; i <= 3; i++) begin
      m_w = m_w + 1'b1;
      step(0, 0, 0, '0, 0);
    end
    // Fill to full occupancy, then drain 16 words
    while (m_w != 5'd16) begin
      m_w = m_w + 1'b1;
      step(0, 0, 0, '0, 0);
    end
    for (int i = 0; i < 16; i++) step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);

    // Underflow: set, set-wins-over-clear, clear alone
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // Flush: move to rbin=5, then wbin=12, then flush with rinc
    m_w = 5'd5;
    step(0, 1, 0, '0, 0);
    m_w = 5'd12;
    step(0, 0, 0, '0, 0);
    step(1, 1, 0, '0, 0);

    // Almost-empty threshold load at level 6, then read down to 5
    m_w = 5'd18;
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, 5'd6, 0);
    step(0, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    // thr=0 tracks empty; thr=16 pins almost-empty high
    step(0, 0, 1, 5'd0, 0);
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, '0, 0);
    step(0, 0, 1, 5'd16, 0);
    m_w = m_w + 5'd16;
    step(0, 0, 0, '0, 0);
    step(1, 0, 1, 5'd3, 0);

    // Continuous traffic across several pointer wraps
    reads = 0;
    for (int i = 0; i < 260; i++) begin
      logic inc;
      d = m_w - m_r;
      if (d < 16 && $urandom_range(0, 4) != 0) m_w = m_w + 1'b1;
      inc = ($urandom_range(0, 3) != 0);
      if (inc && !m_empty) reads++;
      step(inc, 0, 0, '0, ($urandom_range(0, 15) == 0));
    end
    check("wrap_reads_gt_96", (reads > 96), 1);

    // Asynchronous reset mid-stream, away from any clock edge
    m_w = m_w + 1'b1;
    step(0, 0, 0, '0, 0);
    @(negedge rclk);
    rinc = 1'b1;
    #2 rrst = 1'b1;
    #1 check_reset("async_rst");
    @(negedge rclk);
    model_reset();
    rrst = 1'b0; rinc = 1'b0; rq2_wptr = '0;
    for (int i = 0; i < 3; i++) begin
      m_w = m_w + 1'b1;
      step(0, 0, 0, '0, 0);
    end
    step(1, 0, 0, '0, 0);

    @(posedge rclk);
    #3;
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
